fpu_arbiter: RTL and testbench

Shares one fpu adder instance between two independent requesters (requester 0 and requester 1), with round-robin arbitration.
- The fpu has no start/done handshake and recomputes continuously from its operand inputs.
- This block latches the granted operands onto the fpu inputs and holds them stable for a fixed settle window.
- It then captures data_out/status_out and returns them on a valid/ready response channel tagged with the requester id.
- It sits between the operand sources (register file / test sequencer) and the fpu.

---
 rtl/fpu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one free-running fpu adder between two requesters.
// The granted operands are registered onto the fpu inputs and held for
// WAIT_CYCLES. The fpu result and status are then captured and returned on a
// tagged response channel. Grants are round-robin between the two requesters.
//
// Handshake semantics (all channels): a transfer happens at a rising edge of
// clock100KHz where valid && ready are both high. valid, once raised by the
// source, is expected to stay high with stable payload until that transfer.
// ready never depends on the ready of a downstream channel in the same cycle.
// rsp_valid/rsp_id/rsp_data/rsp_status stay stable until the transfer.
module fpu_arbiter #(
  parameter int WAIT_CYCLES = 72,
  parameter int CNT_W       = 7
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] fpu_op_a,
  output logic [31:0] fpu_op_b,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_status,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last settle cycle: capture happens when the counter reaches it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;

  logic             any_valid;
  logic             sel_id;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             grant;
  logic             cnt_done;
  logic             rsp_fire;

  // Round-robin selection: a lone requester wins, a tie goes to the one
  // that was not granted last time.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_grant;
    end else begin
      sel_id = req1_valid;
    end
    sel_a = sel_id ? req1_a : req0_a;
    sel_b = sel_id ? req1_b : req0_b;
  end

  // Qualified events used by both the FSM and the datapath.
  always_comb begin
    grant    = (state == S_IDLE) && any_valid;
    cnt_done = (cnt == CNT_LAST);
    rsp_fire = (state == S_RESP) && rsp_ready;
  end

  // State register.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> WAIT on grant, WAIT -> RESP at end of settle
  // window, RESP -> IDLE on response handshake (no grant in that same cycle).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state: only the selected requester sees ready, and
  // only while idle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy       = 1'b0;
        req0_ready = any_valid && !sel_id;
        req1_ready = any_valid &&  sel_id;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath: latch operands on grant, run the settle counter, capture the
  // fpu outputs at the end of the window and hold them until accepted.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      fpu_op_a   <= 32'd0;
      fpu_op_b   <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_status <= 4'd0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      if (grant) begin
        fpu_op_a   <= sel_a;
        fpu_op_b   <= sel_b;
        rsp_id     <= sel_id;
        last_grant <= sel_id;
        cnt        <= '0;
      end
      if (state == S_WAIT) begin
        if (cnt_done) begin
          rsp_data   <= fpu_data;
          rsp_status <= fpu_status;
          rsp_valid  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed stimulus against fpu_arbiter with a behavioural
// fpu that recomputes in 32-cycle passes and reports status one pass late.
// Expected responses are pushed at each request acceptance and popped by a
// monitor at each response handshake.
`timescale 1ns/1ps
module tb_fpu_arbiter;

  localparam int WAIT_CYCLES = 72;
  localparam int TIMEOUT     = 1000;

  // Operand table and hand-computed fpu results (1 sign, 6 exp, 25 mant).
  localparam logic [31:0] VA [6] = '{32'h0200_0000, 32'h0200_0001, 32'h0200_0001,
                                     32'h0600_0000, 32'h8200_0000, 32'h7E00_0000};
  localparam logic [31:0] VB [6] = '{32'h0200_0000, 32'h0200_0001, 32'h0200_0000,
                                     32'h0600_0000, 32'h8200_0000, 32'h7E00_0000};
  localparam logic [31:0] ED [6] = '{32'h0400_0000, 32'h0400_0001, 32'h0400_0000,
                                     32'h0800_0000, 32'h8400_0000, 32'h7E00_0000};
  localparam logic [3:0]  ES [6] = '{4'b0001, 4'b0001, 4'b0010,
                                     4'b0001, 4'b0001, 4'b0100};

  logic        clock100KHz;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  fpu_status;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_status;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  int r0_idx = 0;
  int r1_idx = 0;
  logic        prev_rsp_valid = 1'b0;
  logic [36:0] exp_q[$];
  logic        grant_log[$];

  fpu_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(7)) dut (
    .clock100KHz(clock100KHz), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_data(fpu_data), .fpu_status(fpu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clock100KHz = 1'b0;
  always #5000 clock100KHz = ~clock100KHz;

  always @(posedge clock100KHz) cyc = cyc + 1;

  initial begin
    #(64'd20000 * 64'd10000);
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural fpu ----------------
  // Equal-exponent, equal-sign adder; exponent 0x3F saturates as overflow.
  function automatic logic [35:0] fpu_add(input logic [31:0] a, input logic [31:0] b);
    logic [26:0] sum;
    logic [5:0]  e_next;
    sum    = {2'b01, a[24:0]} + {2'b01, b[24:0]};
    e_next = a[30:25] + 6'd1;
    if (a[30:25] == 6'h3F) begin
      fpu_add = {a[31], 6'h3F, 25'd0, 4'b0100};
    end else begin
      fpu_add = {a[31], e_next, sum[25:1], (sum[0] ? 4'b0010 : 4'b0001)};
    end
  endfunction

  logic [35:0] fpu_next;
  logic [4:0]  pass_cnt = 5'd0;
  logic [3:0]  pend_status = 4'b0000;
  assign fpu_next = fpu_add(fpu_op_a, fpu_op_b);

  initial begin
    fpu_data   = 32'd0;
    fpu_status = 4'd0;
  end

  always @(posedge clock100KHz) begin
    pass_cnt <= pass_cnt + 5'd1;
    if (pass_cnt == 5'd31) begin
      fpu_data    <= fpu_next[35:4];
      fpu_status  <= pend_status;
      pend_status <= fpu_next[3:0];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, expected event within %0d cycles", name, TIMEOUT);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock100KHz) begin
    if (!reset) begin
      exp_q.delete();
      prev_rsp_valid = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, ED[r0_idx], ES[r0_idx]});
        grant_log.push_back(1'b0);
        accept_cyc = cyc + 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, ED[r1_idx], ES[r1_idx]});
        grant_log.push_back(1'b1);
        accept_cyc = cyc + 1;
      end
      if (req0_ready && req1_ready) begin
        check("single_ready", {req0_ready, req1_ready}, 2'b00);
      end
      if (rsp_valid && !prev_rsp_valid) begin
        check("latency", 64'(cyc - accept_cyc), 64'(WAIT_CYCLES));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {rsp_valid, rsp_id, rsp_data, rsp_status}, 38'd0);
        end else begin
          check("rsp", {rsp_id, rsp_data, rsp_status}, exp_q.pop_front());
        end
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock100KHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // Issue one operation from an idle DUT; returns just after the transfer edge.
  task automatic send(input int id, input int idx);
    int n;
    if (id == 0) begin
      req0_a = VA[idx]; req0_b = VB[idx]; r0_idx = idx; req0_valid = 1'b1;
    end else begin
      req1_a = VA[idx]; req1_b = VB[idx]; r1_idx = idx; req1_valid = 1'b1;
    end
    @(negedge clock100KHz);
    check(id == 0 ? "ready0_immediate" : "ready1_immediate",
          (id == 0) ? req0_ready : req1_ready, 1'b1);
    n = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && n < TIMEOUT) begin
      @(negedge clock100KHz);
      n++;
    end
    if (n >= TIMEOUT) fail_now("send_accept");
    tick();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock100KHz);
    while ((busy || rsp_valid || exp_q.size() != 0) && n < TIMEOUT) begin
      @(negedge clock100KHz);
      n++;
    end
    if (n >= TIMEOUT) fail_now("wait_idle");
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [36:0] snap;
    int n;
    int seen;
    int r1_seq[3];
    r1_seq = '{5, 0, 1};

    reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    repeat (2) tick();
    check("reset_values", {rsp_valid, rsp_id, rsp_data, rsp_status, fpu_op_a, fpu_op_b,
                           busy, req0_ready, req1_ready}, 73'd0);
    reset = 1'b1;
    tick();

    // Single request from requester 0, ready for exactly one cycle.
    req0_a = VA[0]; req0_b = VB[0]; r0_idx = 0; req0_valid = 1'b1;
    @(negedge clock100KHz);
    check("t1_ready_up", {req0_ready, req1_ready}, 2'b10);
    tick();
    @(negedge clock100KHz);
    check("t1_ready_down", {req0_ready, busy}, 2'b01);
    check("t1_op_latched", {fpu_op_a, fpu_op_b}, {VA[0], VB[0]});
    tick();
    req0_valid = 1'b0;
    wait_idle();

    // Fairness: both requesters continuously valid after a fresh reset.
    do_reset();
    grant_log.delete();
    req0_a = VA[1]; req0_b = VB[1]; r0_idx = 1;
    req1_a = VA[2]; req1_b = VB[2]; r1_idx = 2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < TIMEOUT) begin
      @(negedge clock100KHz);
      n++;
    end
    if (n >= TIMEOUT) fail_now("fair_grants");
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    if (grant_log.size() >= 4) begin
      check("fair_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
    end

    // Back-pressure: hold rsp_ready low for 20 cycles with a pending requester.
    rsp_ready = 1'b0;
    send(0, 3);
    n = 0;
    @(negedge clock100KHz);
    while (!rsp_valid && n < TIMEOUT) begin
      @(negedge clock100KHz);
      n++;
    end
    if (n >= TIMEOUT) fail_now("bp_rsp_valid");
    snap = {1'b0, ED[3], ES[3]};
    tick();
    req1_a = VA[4]; req1_b = VB[4]; r1_idx = 4; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock100KHz);
      check("bp_stall", {rsp_valid, rsp_id, rsp_data, rsp_status, req0_ready, req1_ready},
            {1'b1, snap, 2'b00});
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    check("bp_release", {rsp_valid, req1_ready}, 2'b01);
    @(negedge clock100KHz);
    tick();
    req1_valid = 1'b0;
    wait_idle();

    // Only requester 1 active for three operations.
    for (int k = 0; k < 3; k++) begin
      send(1, r1_seq[k]);
      wait_idle();
    end

    // Reset pulsed ten cycles into the settle window.
    send(0, 2);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("abort_reset", {rsp_valid, rsp_id, rsp_data, rsp_status, fpu_op_a, fpu_op_b,
                          busy, req0_ready, req1_ready}, 73'd0);
    repeat (2) tick();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clock100KHz);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    tick();
    req0_a = VA[0]; req0_b = VB[0]; r0_idx = 0;
    req1_a = VA[1]; req1_b = VB[1]; r1_idx = 1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clock100KHz);
    check("tie_after_reset", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Operand change while the granted operation settles.
    send(0, 3);
    req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
    repeat (5) tick();
    check("hold_ops_early", {fpu_op_a, fpu_op_b}, {VA[3], VB[3]});
    repeat (50) tick();
    check("hold_ops_late", {fpu_op_a, fpu_op_b}, {VA[3], VB[3]});
    wait_idle();
    send(0, 0);
    check("ops_next_grant", {fpu_op_a, fpu_op_b}, {VA[0], VB[0]});
    wait_idle();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
